bus_ctrl_rr: RTL and testbench

Parametrised shared-bus controller: N_M masters arbitrate round-robin for one bus that is address-decoded onto N_S slaves. Successor of the fixed 4-master/8-slave bus, adding width/count parameters, fair rotating priority with grant hold, and a bus-timeout error response for slaves that never assert ready. Sits between CPU/DMA masters and memory/peripheral slaves.

---
 rtl/bus_ctrl_rr.sv | 137 +++++++++++++
 tb/tb_bus_ctrl_rr.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_rr.sv
// rtl/bus_ctrl_rr.sv - round-robin shared-bus controller with address decode and bus timeout
module bus_ctrl_rr #(
    parameter int N_M    = 4,
    parameter int N_S    = 8,
    parameter int DW     = 32,
    parameter int AW     = 30,
    parameter int TO_CYC = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_M-1:0]      mreq_i,
    input  logic [N_M-1:0]      m_as_i,
    input  logic [N_M-1:0]      m_rw_i,
    input  logic [N_M*AW-1:0]   m_addr_i,
    input  logic [N_M*DW-1:0]   m_wr_data_i,
    output logic [N_M-1:0]      grnt_o,
    output logic [N_S-1:0]      s_chip_o,
    output logic [AW-1:0]       s_addr_o,
    output logic                s_as_o,
    output logic                s_rw_o,
    output logic [DW-1:0]       s_wr_data_o,
    input  logic [N_S-1:0]      s_rdy_i,
    input  logic [N_S*DW-1:0]   s_rd_data_i,
    output logic [DW-1:0]       m_rd_data_o,
    output logic                m_rdy_o,
    output logic                m_err_o
);
    localparam int SEL_W = $clog2(N_S);
    localparam int PW    = $clog2(N_M);
    localparam int CW    = $clog2(TO_CYC + 1);

    typedef enum logic {IDLE, OWN} state_e;

    state_e         state_q, state_d;
    logic [N_M-1:0] grnt_q, grnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N_M-1:0]   win_oh;
    logic [PW-1:0]    win_next;
    logic             any_req;
    logic             owner_req;
    logic [SEL_W-1:0] sel;
    logic             sel_rdy;
    logic             timeout;

    // First requester at or after ptr wins; ptr then points just past it.
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        win_oh   = '0;
        win_next = '0;
        found    = 1'b0;
        idx      = '0;
        any_req  = |mreq_i;
        for (int k = 0; k < N_M; k++) begin
            idx = PW'((int'(ptr_q) + k) % N_M);
            if (!found && mreq_i[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_next    = PW'((int'(idx) + 1) % N_M);
            end
        end
    end

    always_comb begin
        s_addr_o    = '0;
        s_as_o      = 1'b0;
        s_rw_o      = 1'b0;
        s_wr_data_o = '0;
        owner_req   = 1'b0;
        for (int i = 0; i < N_M; i++) begin
            if (grnt_q[i]) begin
                s_addr_o    = m_addr_i[i*AW +: AW];
                s_as_o      = m_as_i[i];
                s_rw_o      = m_rw_i[i];
                s_wr_data_o = m_wr_data_i[i*DW +: DW];
                owner_req   = mreq_i[i];
            end
        end
    end

    assign sel      = s_addr_o[AW-1 -: SEL_W];
    assign sel_rdy  = s_rdy_i[sel];
    assign timeout  = (cnt_q == CW'(TO_CYC - 1));
    assign m_rdy_o  = s_as_o & (sel_rdy | timeout);
    assign m_err_o  = s_as_o & ~sel_rdy & timeout;
    assign s_chip_o = s_as_o ? (N_S'(1) << sel) : '0;
    assign m_rd_data_o = (s_as_o && !m_err_o) ? s_rd_data_i[sel*DW +: DW] : '0;
    assign grnt_o   = grnt_q;

    always_comb begin
        state_d = state_q;
        grnt_d  = grnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWN;
                    grnt_d  = win_oh;
                    ptr_d   = win_next;
                end
            end
            OWN: begin
                // Handover happens on the same edge the owner releases: no dead cycle.
                if (!owner_req) begin
                    if (any_req) begin
                        grnt_d = win_oh;
                        ptr_d  = win_next;
                    end else begin
                        state_d = IDLE;
                        grnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grnt_d  = '0;
            end
        endcase
        cnt_d = (s_as_o && !m_rdy_o && (grnt_d == grnt_q)) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grnt_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grnt_q  <= grnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_ctrl_rr.sv
// tb/tb_bus_ctrl_rr.sv - directed self-checking bench for bus_ctrl_rr
module tb_bus_ctrl_rr;
    localparam int N_M = 4;
    localparam int N_S = 8;
    localparam int DW  = 32;
    localparam int AW  = 30;
    localparam int TO  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_M-1:0]    mreq, m_as, m_rw;
    logic [N_M*AW-1:0] m_addr;
    logic [N_M*DW-1:0] m_wr_data;
    logic [N_M-1:0]    grnt;
    logic [N_S-1:0]    s_chip;
    logic [AW-1:0]     s_addr;
    logic              s_as, s_rw;
    logic [DW-1:0]     s_wr_data;
    logic [N_S-1:0]    s_rdy;
    logic [N_S*DW-1:0] s_rd_data;
    logic [DW-1:0]     m_rd_data;
    logic              m_rdy, m_err;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_ctrl_rr #(.N_M(N_M), .N_S(N_S), .DW(DW), .AW(AW), .TO_CYC(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mreq_i(mreq), .m_as_i(m_as), .m_rw_i(m_rw),
        .m_addr_i(m_addr), .m_wr_data_i(m_wr_data),
        .grnt_o(grnt), .s_chip_o(s_chip), .s_addr_o(s_addr),
        .s_as_o(s_as), .s_rw_o(s_rw), .s_wr_data_o(s_wr_data),
        .s_rdy_i(s_rdy), .s_rd_data_i(s_rd_data),
        .m_rd_data_o(m_rd_data), .m_rdy_o(m_rdy), .m_err_o(m_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mreq = '0; m_as = '0; m_rw = '0; m_addr = '0; m_wr_data = '0;
        s_rdy = '0; s_rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_m(input int i, input logic as, input logic rw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_as[i] = as;
        m_rw[i] = rw;
        m_addr[i*AW +: AW] = a;
        m_wr_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        mreq = 4'hF; m_as = 4'hF; s_rdy = 8'hFF;
        #1;
        n_cmp++; if (grnt !== 4'b0) begin n_fail++; $display("FAIL reset_grnt: got %b need 0000", grnt); end
        tick(); tick();
        n_cmp++; if (grnt !== 4'b0) begin n_fail++; $display("FAIL reset_grnt_clk: got %b need 0000", grnt); end
        n_cmp++; if (s_chip !== 8'h0) begin n_fail++; $display("FAIL reset_chip: got %h need 00", s_chip); end
        n_cmp++; if (m_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b need 0", m_rdy); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (grnt !== 4'b0001) begin n_fail++; $display("FAIL reset_release_grnt: got %b need 0001", grnt); end
        n_cmp++; if (s_chip !== 8'h01) begin n_fail++; $display("FAIL reset_release_chip: got %h need 01", s_chip); end
    endtask

    task automatic test_round_robin();
        logic [N_M-1:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        m_as = 4'hF; s_rdy = 8'hFF; mreq = 4'hF;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_cmp++; if (grnt !== exp_g[j]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b need %b", j, grnt, exp_g[j]); end
            n_cmp++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_xfer[%0d]: got %b need 1", j, m_rdy); end
            mreq = 4'hF & ~exp_g[j];
        end
    endtask

    task automatic test_hold();
        do_reset();
        mreq = 4'b0100;
        tick();
        n_cmp++; if (grnt !== 4'b0100) begin n_fail++; $display("FAIL hold_first: got %b need 0100", grnt); end
        mreq = 4'hF;
        for (int c = 2; c <= 10; c++) begin
            tick();
            n_cmp++; if (grnt !== 4'b0100) begin n_fail++; $display("FAIL hold_cyc%0d: got %b need 0100", c, grnt); end
        end
        mreq = 4'b1011;
        tick();
        n_cmp++; if (grnt !== 4'b1000) begin n_fail++; $display("FAIL hold_next: got %b need 1000", grnt); end
    endtask

    task automatic test_decode_read();
        do_reset();
        for (int j = 0; j < N_S; j++) s_rd_data[j*DW +: DW] = 32'h1111_0000 + j;
        s_rd_data[7*DW +: DW] = 32'hFFFF_FFF8;
        set_m(1, 1'b1, 1'b1, 30'h3800_0010, 32'hA5A5_0001);
        set_m(0, 1'b1, 1'b0, 30'h0000_0004, 32'h0000_00EE);
        mreq = 4'b0010; s_rdy = 8'h80;
        tick();
        n_cmp++; if (s_chip !== 8'h80) begin n_fail++; $display("FAIL dec_chip: got %h need 80", s_chip); end
        n_cmp++; if (m_rd_data !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL dec_rdata: got %h need FFFFFFF8", m_rd_data); end
        n_cmp++; if (m_rdy !== 1'b1 || m_err !== 1'b0) begin n_fail++; $display("FAIL dec_rdy_err: got %b%b need 10", m_rdy, m_err); end
        n_cmp++; if (s_addr !== 30'h3800_0010 || s_rw !== 1'b1) begin n_fail++; $display("FAIL dec_addr_rw: got %h/%b need 38000010/1", s_addr, s_rw); end
        n_cmp++; if (s_wr_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL dec_wdata: got %h need A5A50001", s_wr_data); end
        s_rdy = 8'h7F;
        #1;
        n_cmp++; if (m_rdy !== 1'b0) begin n_fail++; $display("FAIL dec_unsel_rdy: got %b need 0", m_rdy); end
        m_as[1] = 1'b0;
        #1;
        n_cmp++; if (s_chip !== 8'h00 || m_rd_data !== 32'h0) begin n_fail++; $display("FAIL dec_nostrobe: got %h/%h need 00/0", s_chip, m_rd_data); end
    endtask

    task automatic test_timeout();
        logic exp_rdy, exp_err;
        do_reset();
        s_rd_data[3*DW +: DW] = 32'hDEAD_BEEF;
        set_m(0, 1'b1, 1'b1, 30'h1800_0000, 32'h0);
        mreq = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 8) s_rdy = 8'h08;
            #1;
            exp_rdy = (c == 4) || (c == 8);
            exp_err = (c == 4);
            n_cmp++; if (m_rdy !== exp_rdy || m_err !== exp_err) begin n_fail++; $display("FAIL to_cyc%0d: rdy/err got %b%b need %b%b", c, m_rdy, m_err, exp_rdy, exp_err); end
            if (c == 1) begin
                n_cmp++; if (m_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata_pass: got %h need DEADBEEF", m_rd_data); end
            end
            if (c == 4) begin
                n_cmp++; if (m_rd_data !== 32'h0) begin n_fail++; $display("FAIL to_rdata_zero: got %h need 0", m_rd_data); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(0, 1'b1, 1'b1, 30'h1800_0000, 32'h0);
        s_rd_data[3*DW +: DW] = 32'h1234_5678;
        mreq = 4'b0001;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grnt !== 4'b0 || s_chip !== 8'h0 || s_as !== 1'b0 || s_addr !== 30'h0)
            begin n_fail++; $display("FAIL mid_reset_bus: got %b/%h/%b/%h need 0", grnt, s_chip, s_as, s_addr); end
        n_cmp++; if (m_rdy !== 1'b0 || m_err !== 1'b0 || m_rd_data !== 32'h0)
            begin n_fail++; $display("FAIL mid_reset_resp: got %b/%b/%h need 0", m_rdy, m_err, m_rd_data); end
        tick();
        mreq = 4'hF;
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                n_cmp++; if (grnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr0: got %b need 0001", grnt); end
            end
            n_cmp++; if (m_err !== (c == 4)) begin n_fail++; $display("FAIL mid_cnt_cyc%0d: got %b need %b", c, m_err, (c == 4)); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_hold();
        test_decode_read();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
